// File: rtl/stopwatch_ctrl.sv
// ---------------------------------------------------------------------------
// stopwatch_ctrl
//
// Control FSM for the stopwatch timer_counter datapath. Two raw push-buttons
// (START/STOP and CLEAR/LAP) are synchronised and debounced against the 1 ms
// timebase. Each accepted press becomes a single-cycle event. The FSM turns
// these events into the run level and the clear pulse for the counter. It
// also freezes a lap value for the display path.
//
// Ports:
//   I_CLK         system clock
//   I_RSTN        asynchronous active-low reset
//   I_EN_1MS      one-cycle 1 ms tick (shared with timer_counter)
//   I_BTN_SS      raw START/STOP button, active-high, asynchronous, bouncing
//   I_BTN_CL      raw CLEAR/LAP button, active-high, asynchronous, bouncing
//   I_TIMER_MS    live millisecond count from timer_counter (0-999)
//   I_TIMER_SEC   live second count from timer_counter (0-59)
//   O_START_EN    counter run level
//   O_CLEAR_EN    one-cycle clear pulse to the counter
//   O_DISP_MS     millisecond value for the display
//   O_DISP_SEC    second value for the display
//   O_LAP_ACTIVE  high while the display is frozen on the lap value
//   O_STATE       FSM state: IDLE=0, RUN=1, LAP=2, STOP=3
// ---------------------------------------------------------------------------
module stopwatch_ctrl #(
    parameter int DEBOUNCE_MS = 10,
    parameter int DB_CNT_W    = 4
) (
    input  logic        I_CLK,
    input  logic        I_RSTN,
    input  logic        I_EN_1MS,
    input  logic        I_BTN_SS,
    input  logic        I_BTN_CL,
    input  logic [9:0]  I_TIMER_MS,
    input  logic [5:0]  I_TIMER_SEC,
    output logic        O_START_EN,
    output logic        O_CLEAR_EN,
    output logic [9:0]  O_DISP_MS,
    output logic [5:0]  O_DISP_SEC,
    output logic        O_LAP_ACTIVE,
    output logic [1:0]  O_STATE
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_LAP  = 2'd2;
    localparam logic [1:0] ST_STOP = 2'd3;

    localparam logic [DB_CNT_W-1:0] DB_LAST = DB_CNT_W'(DEBOUNCE_MS - 1);

    // Button index 0 is START/STOP, index 1 is CLEAR/LAP.
    logic [1:0]          btn_raw;
    logic [1:0]          btn_meta;
    logic [1:0]          btn_sync;
    logic [1:0]          db_level;
    logic [DB_CNT_W-1:0] db_cnt [2];
    logic [1:0]          press_evt;

    logic [1:0] state;
    logic [1:0] next_state;
    logic       clear_req;
    logic       lap_capture;
    logic       start_en;
    logic       clear_en;
    logic [9:0] lap_ms;
    logic [5:0] lap_sec;

    logic ss_evt;
    logic cl_evt;

    assign btn_raw = {I_BTN_CL, I_BTN_SS};
    assign ss_evt  = press_evt[0];
    assign cl_evt  = press_evt[1];

    // Input conditioning for both buttons. A two-flop synchroniser feeds a
    // counter that only runs while the synchronised level disagrees with the
    // accepted level. Any agreement (a bounce back) restarts the count.
    // Once the disagreement has lasted DEBOUNCE_MS ticks, the new level is
    // accepted. A rising acceptance is registered as a one-cycle press event.
    // Releases are accepted silently, so a held button yields one event only.
    always_ff @(posedge I_CLK or negedge I_RSTN) begin
        if (!I_RSTN) begin
            btn_meta  <= '0;
            btn_sync  <= '0;
            db_level  <= '0;
            press_evt <= '0;
            for (int i = 0; i < 2; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            btn_meta <= btn_raw;
            btn_sync <= btn_meta;
            for (int i = 0; i < 2; i++) begin
                press_evt[i] <= 1'b0;
                if (btn_sync[i] == db_level[i]) begin
                    db_cnt[i] <= '0;
                end else if (I_EN_1MS) begin
                    if (db_cnt[i] == DB_LAST) begin
                        db_level[i]  <= btn_sync[i];
                        db_cnt[i]    <= '0;
                        press_evt[i] <= btn_sync[i];
                    end else begin
                        db_cnt[i] <= db_cnt[i] + 1'b1;
                    end
                end
            end
        end
    end

    // Next-state decode. START/STOP takes priority, so when both events land
    // in the same cycle CLEAR/LAP is simply ignored. The clear pulse is only
    // requested from states where the counter is already halted, so it can
    // never overlap a high run level.
    always_comb begin
        next_state  = state;
        clear_req   = 1'b0;
        lap_capture = 1'b0;
        case (state)
            ST_IDLE: begin
                if (ss_evt) begin
                    next_state = ST_RUN;
                end else if (cl_evt) begin
                    clear_req = 1'b1;
                end
            end
            ST_RUN: begin
                if (ss_evt) begin
                    next_state = ST_STOP;
                end else if (cl_evt) begin
                    next_state  = ST_LAP;
                    lap_capture = 1'b1;
                end
            end
            ST_LAP: begin
                if (ss_evt) begin
                    next_state = ST_STOP;
                end else if (cl_evt) begin
                    next_state = ST_RUN;
                end
            end
            ST_STOP: begin
                if (ss_evt) begin
                    next_state = ST_RUN;
                end else if (cl_evt) begin
                    next_state = ST_IDLE;
                    clear_req  = 1'b1;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // State, run level and clear pulse all update on the same edge, so the
    // counter controls never lag the reported state. The run level stays high
    // through LAP because the counter keeps running behind the frozen display.
    // The lap value is sampled on the very edge the FSM enters LAP.
    always_ff @(posedge I_CLK or negedge I_RSTN) begin
        if (!I_RSTN) begin
            state    <= ST_IDLE;
            start_en <= 1'b0;
            clear_en <= 1'b0;
            lap_ms   <= '0;
            lap_sec  <= '0;
        end else begin
            state    <= next_state;
            start_en <= (next_state == ST_RUN) || (next_state == ST_LAP);
            clear_en <= clear_req;
            if (lap_capture) begin
                lap_ms  <= I_TIMER_MS;
                lap_sec <= I_TIMER_SEC;
            end
        end
    end

    // The display shows the frozen lap value only while in LAP. It shows the
    // live counter in every other state, including straight out of reset.
    always_comb begin
        if (state == ST_LAP) begin
            O_DISP_MS  = lap_ms;
            O_DISP_SEC = lap_sec;
        end else begin
            O_DISP_MS  = I_TIMER_MS;
            O_DISP_SEC = I_TIMER_SEC;
        end
    end

    assign O_START_EN   = start_en;
    assign O_CLEAR_EN   = clear_en;
    assign O_LAP_ACTIVE = (state == ST_LAP);
    assign O_STATE      = state;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_stopwatch_ctrl
//
// Scoreboarded bench for stopwatch_ctrl. Each press issued to the DUT is run
// through a table-driven model of the stopwatch rules. The expected result is
// queued when the press is issued. A monitor pops the queue each time the DUT
// changes state or emits a clear pulse. Between such outputs, the monitor
// periodically checks that state and display hold steady. The 1 ms tick is
// scaled down to TICK_CYC clock cycles to keep run time short.
// ---------------------------------------------------------------------------
module tb_stopwatch_ctrl;

    localparam int DEBOUNCE_MS = 10;
    localparam int TICK_CYC    = 8;

    typedef struct {
        int state;
        bit start_en;
        bit clear_en;
        bit lap_active;
        int disp_ms;
        int disp_sec;
    } exp_t;

    logic       I_CLK;
    logic       I_RSTN;
    logic       I_EN_1MS;
    logic       I_BTN_SS;
    logic       I_BTN_CL;
    logic [9:0] I_TIMER_MS;
    logic [5:0] I_TIMER_SEC;
    logic       O_START_EN;
    logic       O_CLEAR_EN;
    logic [9:0] O_DISP_MS;
    logic [5:0] O_DISP_SEC;
    logic       O_LAP_ACTIVE;
    logic [1:0] O_STATE;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    bit tick_en   = 1'b1;
    bit timer_run = 1'b0;
    int timer_ms  = 0;
    int timer_sec = 0;

    // Stopwatch rules as lookup tables indexed by state (IDLE, RUN, LAP, STOP).
    int model_state = 0;
    int ss_next[4]  = '{1, 3, 3, 1};
    int cl_next[4]  = '{0, 2, 1, 0};
    bit cl_clear[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    assign I_TIMER_MS  = 10'(timer_ms);
    assign I_TIMER_SEC = 6'(timer_sec);

    stopwatch_ctrl #(
        .DEBOUNCE_MS(DEBOUNCE_MS),
        .DB_CNT_W   (4)
    ) dut (
        .I_CLK       (I_CLK),
        .I_RSTN      (I_RSTN),
        .I_EN_1MS    (I_EN_1MS),
        .I_BTN_SS    (I_BTN_SS),
        .I_BTN_CL    (I_BTN_CL),
        .I_TIMER_MS  (I_TIMER_MS),
        .I_TIMER_SEC (I_TIMER_SEC),
        .O_START_EN  (O_START_EN),
        .O_CLEAR_EN  (O_CLEAR_EN),
        .O_DISP_MS   (O_DISP_MS),
        .O_DISP_SEC  (O_DISP_SEC),
        .O_LAP_ACTIVE(O_LAP_ACTIVE),
        .O_STATE     (O_STATE)
    );

    // 10 ns system clock.
    initial begin
        I_CLK = 1'b0;
        forever #5 I_CLK = ~I_CLK;
    end

    // Scaled 1 ms timebase. When timer_run is set, this block also plays the
    // role of timer_counter and advances the live time on every tick.
    initial begin
        int phase;
        phase    = 0;
        I_EN_1MS = 1'b0;
        forever begin
            @(posedge I_CLK);
            #1;
            phase    = (phase + 1) % TICK_CYC;
            I_EN_1MS = tick_en && (phase == 0);
            if (I_EN_1MS && timer_run) begin
                if (timer_ms == 999) begin
                    timer_ms  = 0;
                    timer_sec = (timer_sec + 1) % 60;
                end else begin
                    timer_ms = timer_ms + 1;
                end
            end
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge I_CLK);
        #1;
    endtask

    task automatic driveButtons(input bit ss, input bit cl, input bit level);
        I_BTN_SS = ss ? level : 1'b0;
        I_BTN_CL = cl ? level : 1'b0;
    endtask

    // One complete press: a bouncy rising edge, a hold long enough to be
    // accepted, then a bouncy release and an idle gap. The live time is frozen
    // at (ms, sec) during the press, so the expected display at the event is
    // known. It runs again from the release onward.
    task automatic applyStimulus(input bit ss, input bit cl, input int ms, input int sec,
                                 input int extra_hold);
        exp_t e;
        int   nb;
        timer_run = 1'b0;
        timer_ms  = ms;
        timer_sec = sec;
        if (tick_en && (ss || cl)) begin
            int ns;
            bit clr;
            if (ss) begin
                ns  = ss_next[model_state];
                clr = 1'b0;
            end else begin
                ns  = cl_next[model_state];
                clr = cl_clear[model_state];
            end
            e.state      = ns;
            e.start_en   = (ns == 1) || (ns == 2);
            e.clear_en   = clr;
            e.lap_active = (ns == 2);
            e.disp_ms    = ms;
            e.disp_sec   = sec;
            exp_q.push_back(e);
            model_state = ns;
        end
        nb = int'($urandom_range(1, 4));
        for (int i = 0; i < nb; i++) begin
            driveButtons(ss, cl, 1'b1);
            waitCycles(int'($urandom_range(1, 3 * TICK_CYC)));
            driveButtons(ss, cl, 1'b0);
            waitCycles(int'($urandom_range(1, 3 * TICK_CYC)));
        end
        driveButtons(ss, cl, 1'b1);
        waitCycles((DEBOUNCE_MS + 3) * TICK_CYC + extra_hold);
        timer_run = 1'b1;
        nb = int'($urandom_range(0, 3));
        for (int i = 0; i < nb; i++) begin
            driveButtons(ss, cl, 1'b0);
            waitCycles(int'($urandom_range(1, 3 * TICK_CYC)));
            driveButtons(ss, cl, 1'b1);
            waitCycles(int'($urandom_range(1, 3 * TICK_CYC)));
        end
        driveButtons(ss, cl, 1'b0);
        waitCycles((DEBOUNCE_MS + 3) * TICK_CYC + int'($urandom_range(0, 4 * TICK_CYC)));
    endtask

    task automatic pulseReset(input int cycles);
        checkOutput("pending_before_reset", exp_q.size(), 0);
        exp_q.delete();
        I_RSTN      = 1'b0;
        model_state = 0;
        waitCycles(cycles);
        I_RSTN = 1'b1;
        waitCycles(5);
    endtask

    // Monitor. While reset is held, everything must sit at reset values with
    // the display live. Otherwise, a state change or clear pulse is a DUT
    // output that must match the head of the scoreboard. Between outputs, the
    // last accepted result must hold steady. In particular, a frozen lap value
    // must stay put while the live time keeps moving.
    initial begin
        exp_t cur;
        exp_t e;
        int   prev_state;
        int   since;
        bit   after_trans;
        int   want_ms;
        int   want_sec;
        cur         = '{0, 1'b0, 1'b0, 1'b0, 0, 0};
        prev_state  = 0;
        since       = 0;
        after_trans = 1'b0;
        forever begin
            @(negedge I_CLK);
            if (!I_RSTN) begin
                checkOutput("rst_state", int'(O_STATE), 0);
                checkOutput("rst_start_en", int'(O_START_EN), 0);
                checkOutput("rst_clear_en", int'(O_CLEAR_EN), 0);
                checkOutput("rst_lap_active", int'(O_LAP_ACTIVE), 0);
                checkOutput("rst_disp_ms", int'(O_DISP_MS), timer_ms);
                checkOutput("rst_disp_sec", int'(O_DISP_SEC), timer_sec);
                checkOutput("rst_lap_ms_reg", int'(dut.lap_ms), 0);
                checkOutput("rst_lap_sec_reg", int'(dut.lap_sec), 0);
                cur         = '{0, 1'b0, 1'b0, 1'b0, 0, 0};
                prev_state  = 0;
                after_trans = 1'b0;
            end else if ((int'(O_STATE) != prev_state) || O_CLEAR_EN) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_output: state %0d clear %0d, expected no change at %0t",
                             O_STATE, O_CLEAR_EN, $time);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("evt_state", int'(O_STATE), e.state);
                    checkOutput("evt_start_en", int'(O_START_EN), int'(e.start_en));
                    checkOutput("evt_clear_en", int'(O_CLEAR_EN), int'(e.clear_en));
                    checkOutput("evt_lap_active", int'(O_LAP_ACTIVE), int'(e.lap_active));
                    checkOutput("evt_disp_ms", int'(O_DISP_MS), e.disp_ms);
                    checkOutput("evt_disp_sec", int'(O_DISP_SEC), e.disp_sec);
                    cur = e;
                end
                prev_state  = int'(O_STATE);
                after_trans = 1'b1;
            end else begin
                since++;
                if (after_trans || (since % 16 == 0)) begin
                    after_trans = 1'b0;
                    want_ms  = cur.lap_active ? cur.disp_ms  : timer_ms;
                    want_sec = cur.lap_active ? cur.disp_sec : timer_sec;
                    checkOutput("hold_state", int'(O_STATE), cur.state);
                    checkOutput("hold_start_en", int'(O_START_EN), int'(cur.start_en));
                    checkOutput("hold_clear_en", int'(O_CLEAR_EN), 0);
                    checkOutput("hold_lap_active", int'(O_LAP_ACTIVE), int'(cur.lap_active));
                    checkOutput("hold_disp_ms", int'(O_DISP_MS), want_ms);
                    checkOutput("hold_disp_sec", int'(O_DISP_SEC), want_sec);
                end
            end
        end
    end

    // Directed scenarios first, then a randomized stream of presses.
    initial begin
        int r;
        int w;
        int hold;
        I_RSTN    = 1'b0;
        I_BTN_SS  = 1'b0;
        I_BTN_CL  = 1'b0;
        timer_ms  = 321;
        timer_sec = 17;
        waitCycles(10);
        I_RSTN = 1'b1;
        waitCycles(5);

        $display("[TB] start/stop from IDLE with bounce and long hold");
        applyStimulus(1'b1, 1'b0, 500, 0, 30 * TICK_CYC);

        $display("[TB] lap capture at 4.123 and release back to RUN");
        applyStimulus(1'b0, 1'b1, 123, 4, 0);
        waitCycles(40 * TICK_CYC);
        applyStimulus(1'b0, 1'b1, 777, 9, 0);

        $display("[TB] stop then clear");
        applyStimulus(1'b1, 1'b0, 10, 12, 0);
        applyStimulus(1'b0, 1'b1, 20, 12, 0);

        $display("[TB] clear while IDLE");
        applyStimulus(1'b0, 1'b1, 5, 0, 0);

        $display("[TB] simultaneous presses in RUN");
        applyStimulus(1'b1, 1'b0, 100, 1, 0);
        applyStimulus(1'b1, 1'b1, 200, 2, 0);

        $display("[TB] STOP to RUN, LAP to STOP");
        applyStimulus(1'b1, 1'b0, 300, 3, 0);
        applyStimulus(1'b0, 1'b1, 400, 3, 0);
        applyStimulus(1'b1, 1'b0, 450, 3, 0);
        applyStimulus(1'b1, 1'b0, 460, 3, 0);

        $display("[TB] reset while in LAP");
        applyStimulus(1'b0, 1'b1, 999, 59, 0);
        pulseReset(3);
        waitCycles(4 * TICK_CYC);

        $display("[TB] press with the 1 ms tick stopped");
        tick_en = 1'b0;
        applyStimulus(1'b1, 1'b0, 50, 5, 20 * TICK_CYC);
        tick_en = 1'b1;
        waitCycles(4 * TICK_CYC);

        $display("[TB] randomized presses");
        for (int i = 0; i < 30; i++) begin
            r    = int'($urandom_range(0, 9));
            hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 30 * TICK_CYC))
                                               : int'($urandom_range(0, TICK_CYC));
            applyStimulus(r < 9, r >= 5, int'($urandom_range(0, 999)), int'($urandom_range(0, 59)),
                          hold);
        end

        w = 0;
        while (exp_q.size() != 0 && w < 2000) begin
            waitCycles(1);
            w++;
        end
        checkOutput("queue_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Control FSM for the stopwatch `timer_counter` datapath. It synchronises and debounces two raw push-buttons (START/STOP and CLEAR/LAP) and drives the counter's I_START_EN and I_CLEAR_EN. It also selects between the live timer value and a frozen lap value for the display path. It sits between the board buttons and the 1 ms timebase on one side, and `timer_counter` plus the 7-seg driver on the other.

Parameters:
DEBOUNCE_MS, 10, number of consecutive I_EN_1MS ticks a synchronised button level must hold before it is accepted
DB_CNT_W, 4, width of each debounce counter; must hold DEBOUNCE_MS

Ports:
I_CLK  input  1  system clock (160 MHz)
I_RSTN  input  1  asynchronous active-low reset
I_EN_1MS  input  1  one-cycle 1 ms tick, shared with `timer_counter`
I_BTN_SS  input  1  raw START/STOP button, active-high, asynchronous, bouncing
I_BTN_CL  input  1  raw CLEAR/LAP button, active-high, asynchronous, bouncing
I_TIMER_MS  input  10  live ms count from `timer_counter` (0-999)
I_TIMER_SEC  input  6  live sec count from `timer_counter` (0-59)
O_START_EN  output  1  level; counter runs while high
O_CLEAR_EN  output  1  one-cycle clear pulse to the counter
O_DISP_MS  output  10  ms value for display
O_DISP_SEC  output  6  sec value for display
O_LAP_ACTIVE  output  1  high while the display is frozen
O_STATE  output  2  FSM state: IDLE=0, RUN=1, LAP=2, STOP=3

Behaviour:
- Async reset, asserted: state=IDLE; O_START_EN=0; O_CLEAR_EN=0; O_LAP_ACTIVE=0; lap registers=0; debounced levels=0; debounce counters=0. Display shows live inputs.
- Input conditioning, per button:
  - 2-flop synchroniser.
  - Debounce counter: clears whenever the synchronised level equals the debounced level. Otherwise it increments on I_EN_1MS.
  - When the counter reaches DEBOUNCE_MS-1 and I_EN_1MS is high, the debounced level toggles and the counter clears.
  - Press event = 0->1 edge of the debounced level, registered, 1 cycle wide. Releases generate no event.
- Simultaneous SS and CL events in the same cycle: SS is acted on, CL is dropped.
- FSM transitions (taken on the edge after the event):
  - IDLE: SS -> RUN. CL -> stay IDLE, issue clear pulse.
  - RUN: SS -> STOP. CL -> LAP, capture lap.
  - LAP: SS -> STOP, display returns to live. CL -> RUN, display returns to live.
  - STOP: SS -> RUN. CL -> IDLE, issue clear pulse.
- Lap capture: lap registers take I_TIMER_MS/I_TIMER_SEC as sampled on the same clock edge the FSM enters LAP.
- O_START_EN: registered, high exactly when next state is RUN or LAP. It changes on the same edge as O_STATE.
- O_CLEAR_EN: registered, high for exactly one cycle on the edge where the transition issuing the clear occurs. It is never high while O_START_EN=1.
- O_LAP_ACTIVE: high exactly when state=LAP.
- Display mux (combinational from registered state):
  - state=LAP: O_DISP_* = lap registers.
  - Any other state: O_DISP_* = live I_TIMER_*.
- Latency: raw button stable -> event takes 2 sync cycles plus DEBOUNCE_MS ticks plus 1 cycle. Event -> outputs take 1 cycle.
- Held button: exactly one event per press, regardless of hold length.
- The FSM does not track counter wrap (59.999 s -> 0). The counter wraps itself and the controller keeps RUN.
- Reset mid-operation (any state, including LAP or a clear pulse in flight): immediate return to reset values. A pending event is discarded.
- I_EN_1MS absent: debounce counters never advance and no events occur. This is not an error.

Test Plan:
- Reset: hold I_RSTN=0 for 100 ns with buttons idle -> O_STATE=0, O_START_EN=0, O_CLEAR_EN=0, O_LAP_ACTIVE=0, O_DISP_* = I_TIMER_*.
- Bounce: DEBOUNCE_MS=10; toggle I_BTN_SS every 2 ms for 12 ms, then hold high 30 ms -> exactly one SS event. O_STATE 0->1 and O_START_EN=1 about 10 ms after the final rising edge. No change on release.
- Lap: in RUN, press CL when I_TIMER_SEC=4 and I_TIMER_MS=123 -> O_STATE=2, O_DISP=4/123 held while the inputs advance, O_START_EN stays 1. Press CL again -> O_STATE=1, display follows the live value.
- Stop and clear: in RUN, press SS -> O_STATE=3, O_START_EN=0. Press CL -> O_CLEAR_EN high for exactly 1 cycle, O_STATE=0.
- Simultaneous events: in RUN, force SS and CL debounced edges on the same cycle -> O_STATE=3, no lap capture, O_LAP_ACTIVE=0.
- Reset mid-LAP: pulse I_RSTN low in LAP -> O_STATE=0, O_LAP_ACTIVE=0, O_START_EN=0, display live, lap registers=0.
